truth_table_checker: RTL and testbench

Sequential equivalence checker for small combinational functions, the receiving end of the truth-table test flow. The block drives every input combination {x,y,...} onto a pair of combinational functions, an original expression and its simplified form. It samples both outputs after a settle window and records which minterms disagree. It sits beside the fxyz-style function modules and replaces console-driven sweeping with a self-checking hardware sweep that reports pass/fail, a mismatch mask and a count.

---
 rtl/truth_table_checker.sv | 146 ++++++++++++++
 tb/tb_truth_table_checker.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_checker.sv
// Sweeps every minterm through two combinational functions and records where they disagree.
// Optional truth-table capture of s_a is built only when TT_CAPTURE_EN is defined.
module truth_table_checker #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 s_a,
    input  logic                 s_b,
    output logic [N_IN-1:0]      vec,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2**N_IN-1:0]   mis_mask,
    output logic [N_IN:0]        mis_count,
    output logic [N_IN-1:0]      first_mis,
    output logic [2**N_IN-1:0]   table_a
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_t              r_state;
    state_t              w_next;
    logic                w_accept;
    logic                w_sample;
    logic                w_last;
    logic                w_mis;
    logic [3:0]          r_settle;
    logic [N_IN-1:0]     r_vec;
    logic                r_busy;
    logic                r_done;
    logic [2**N_IN-1:0]  r_mis_mask;
    logic [N_IN:0]       r_mis_count;
    logic [N_IN-1:0]     r_first_mis;

    assign w_last = (r_vec == '1);
    assign w_mis  = s_a ^ s_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_sample = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (r_settle == '0) begin
                    w_next = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                w_sample = 1'b1;
                w_next   = w_last ? S_DONE : S_DRIVE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_settle    <= '0;
            r_vec       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mis_mask  <= '0;
            r_mis_count <= '0;
            r_first_mis <= '0;
        end else if (w_accept) begin
            r_settle    <= SETTLE_LOAD;
            r_vec       <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_mis_mask  <= '0;
            r_mis_count <= '0;
            r_first_mis <= '0;
        end else if (r_state == S_DRIVE) begin
            if (r_settle != '0) begin
                r_settle <= r_settle - 4'd1;
            end
        end else if (w_sample) begin
            if (w_mis) begin
                r_mis_mask[r_vec] <= 1'b1;
                r_mis_count       <= r_mis_count + (N_IN+1)'(1);
                if (r_mis_count == '0) begin
                    r_first_mis <= r_vec;
                end
            end
            // Terminal minterm ends the sweep with vec parked on it rather than wrapping.
            if (w_last) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end else begin
                r_vec    <= r_vec + N_IN'(1);
                r_settle <= SETTLE_LOAD;
            end
        end
    end

`ifdef TT_CAPTURE_EN
    logic [2**N_IN-1:0] r_table_a;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_table_a <= '0;
        end else if (w_accept) begin
            r_table_a <= '0;
        end else if (w_sample) begin
            r_table_a[r_vec] <= s_a;
        end
    end

    assign table_a = r_table_a;
`else
    assign table_a = '0;
`endif

    assign vec       = r_vec;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_done && (r_mis_count == '0);
    assign mis_mask  = r_mis_mask;
    assign mis_count = r_mis_count;
    assign first_mis = r_first_mis;

endmodule

// File: tb/tb_truth_table_checker.sv
// Scoreboard bench: directed sweeps push expected results; per-DUT monitors check on done rising.
// Two instances cover N_IN=2/SETTLE=1 and N_IN=3/SETTLE=2.
module tb_truth_table_checker;

    typedef struct {
        logic [7:0] mask;
        logic [3:0] cnt;
        logic [2:0] first;
        logic [7:0] tbl;
        int         done_cyc;
    } exp_t;

`ifdef TT_CAPTURE_EN
    localparam logic [7:0] TBL2 = 8'b0000_0100;
    localparam logic [7:0] TBL3 = 8'b0011_0000;
`else
    localparam logic [7:0] TBL2 = 8'h00;
    localparam logic [7:0] TBL3 = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start2, start3;
    logic       a2, b2, a3, b3;
    int         mode2;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    exp_t       q2[$];
    exp_t       q3[$];

    logic [1:0] vec2;
    logic       busy2, done2, pass2;
    logic [3:0] mask2, tbl2;
    logic [2:0] cnt2;
    logic [1:0] first2;

    logic [2:0] vec3;
    logic       busy3, done3, pass3;
    logic [7:0] mask3, tbl3;
    logic [3:0] cnt3;
    logic [2:0] first3;

    logic       prev2 = 1'b0;
    logic       prev3 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    truth_table_checker #(.N_IN(2), .SETTLE(1)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .s_a(a2), .s_b(b2),
        .vec(vec2), .busy(busy2), .done(done2), .pass(pass2),
        .mis_mask(mask2), .mis_count(cnt2), .first_mis(first2), .table_a(tbl2)
    );

    truth_table_checker #(.N_IN(3), .SETTLE(2)) u_dut3 (
        .clk(clk), .reset(reset), .start(start3), .s_a(a3), .s_b(b3),
        .vec(vec3), .busy(busy3), .done(done3), .pass(pass3),
        .mis_mask(mask3), .mis_count(cnt3), .first_mis(first3), .table_a(tbl3)
    );

    // Functions under test: s_a = x&~y; s_b selected by mode2 (0: same, 1: x|y).
    always_comb begin
        a2 = vec2[1] & ~vec2[0];
        b2 = (mode2 == 1) ? (vec2[1] | vec2[0]) : a2;
        a3 = vec3[2] & ~vec3[1];
        b3 = ~a3;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done2 && !prev2) begin
            if (q2.size() == 0) begin
                chk("dut2_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q2.pop_front();
                chk("dut2_done_cycle", cyc, e.done_cyc);
                chk("dut2_mis_mask", mask2, e.mask);
                chk("dut2_mis_count", cnt2, e.cnt);
                chk("dut2_first_mis", first2, e.first);
                chk("dut2_table_a", tbl2, e.tbl);
                chk("dut2_pass", pass2, (e.cnt == 0));
                chk("dut2_busy_clear", busy2, 1'b0);
                chk("dut2_vec_last", vec2, 2'd3);
            end
        end
        prev2 = done2;
    end

    always @(negedge clk) begin
        exp_t e;
        if (done3 && !prev3) begin
            if (q3.size() == 0) begin
                chk("dut3_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q3.pop_front();
                chk("dut3_done_cycle", cyc, e.done_cyc);
                chk("dut3_mis_mask", mask3, e.mask);
                chk("dut3_mis_count", cnt3, e.cnt);
                chk("dut3_first_mis", first3, e.first);
                chk("dut3_table_a", tbl3, e.tbl);
                chk("dut3_pass", pass3, (e.cnt == 0));
            end
        end
        prev3 = done3;
    end

    task automatic sweep2(input logic [3:0] mask, input logic [2:0] cnt, input logic [1:0] first);
        exp_t e;
        @(negedge clk);
        e.mask = {4'b0, mask}; e.cnt = {1'b0, cnt}; e.first = {1'b0, first};
        e.tbl = TBL2; e.done_cyc = cyc + 1 + 8;
        q2.push_back(e);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        chk("dut2_start_busy", busy2, 1'b1);
        chk("dut2_start_vec", vec2, 2'd0);
        chk("dut2_start_done", done2, 1'b0);
    endtask

    task automatic wait_done2();
        for (int i = 0; i < 100; i++) begin
            if (done2) break;
            @(negedge clk);
        end
        chk("dut2_done_timeout", done2, 1'b1);
    endtask

    initial begin
        exp_t e;
        reset = 1'b1; start2 = 1'b0; start3 = 1'b0; mode2 = 0;
        #3;
        chk("rst_vec", vec2, 0);
        chk("rst_busy", busy2, 0);
        chk("rst_done", done2, 0);
        chk("rst_pass", pass2, 0);
        chk("rst_mask", mask2, 0);
        chk("rst_count", cnt2, 0);
        chk("rst_table", tbl2, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Equivalent pair.
        mode2 = 0;
        sweep2(4'b0000, 3'd0, 2'd0);
        wait_done2();

        // Non-equivalent pair, with a start issued mid-sweep that must be ignored.
        mode2 = 1;
        sweep2(4'b1010, 3'd2, 2'd1);
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        chk("dut2_ignored_start_busy", busy2, 1'b1);
        wait_done2();

        // Restart from DONE with nonzero results: they must clear at the sampling edge.
        repeat (2) @(negedge clk);
        sweep2(4'b1010, 3'd2, 2'd1);
        chk("dut2_restart_mask_clr", mask2, 0);
        chk("dut2_restart_count_clr", cnt2, 0);
        chk("dut2_restart_pass", pass2, 0);
        wait_done2();

        // Async reset during SAMPLE of vec=10.
        mode2 = 1;
        sweep2(4'b1010, 3'd2, 2'd1);
        repeat (5) @(negedge clk);
        chk("dut2_pre_reset_vec", vec2, 2'd2);
        chk("dut2_pre_reset_mask", mask2, 4'b0010);
        #1;
        reset = 1'b1;
        q2.delete();
        #1;
        chk("async_rst_vec", vec2, 0);
        chk("async_rst_busy", busy2, 0);
        chk("async_rst_done", done2, 0);
        chk("async_rst_mask", mask2, 0);
        chk("async_rst_count", cnt2, 0);
        chk("async_rst_first", first2, 0);
        chk("async_rst_table", tbl2, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", busy2, 0);

        mode2 = 0;
        sweep2(4'b0000, 3'd0, 2'd0);
        wait_done2();

        // Width/settle scaling on the 3-input instance.
        @(negedge clk);
        e.mask = 8'hFF; e.cnt = 4'd8; e.first = 3'd0; e.tbl = TBL3;
        e.done_cyc = cyc + 1 + 24;
        q3.push_back(e);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        chk("dut3_start_busy", busy3, 1'b1);
        for (int i = 0; i < 100; i++) begin
            if (done3) break;
            @(negedge clk);
        end
        chk("dut3_done_timeout", done3, 1'b1);

        repeat (3) @(negedge clk);
        chk("dut2_queue_drained", q2.size(), 0);
        chk("dut3_queue_drained", q3.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
